// File: rtl/reg_writeback.sv
// Write-side front end of the register file: merges ALU results and buffered
// load results onto one registered write port, with a starvation guard for loads.

module reg_writeback_slot (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        push,
  input  logic        pop,
  input  logic [4:0]  rd_in,
  input  logic [31:0] data_in,
  output logic        vld,
  output logic [4:0]  rd,
  output logic [31:0] data,
  output logic [31:0] pend
);
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      vld  <= 1'b0;
      rd   <= '0;
      data <= '0;
    end else if (push) begin
      vld  <= 1'b1;
      rd   <= rd_in;
      data <= data_in;
    end else if (pop) begin
      vld  <= 1'b0;
    end
  end

  // r0 is never pushed, but keep its pending bit hard zero regardless
  always_comb begin
    pend = '0;
    if (vld) pend[rd] = 1'b1;
    pend[0] = 1'b0;
  end
endmodule

module reg_writeback #(
  parameter int DEPTH      = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        ALU_VALID,
  input  logic [4:0]  ALU_RD,
  input  logic [31:0] ALU_DATA,
  input  logic        LSU_VALID,
  input  logic [4:0]  LSU_RD,
  input  logic [31:0] LSU_DATA,
  output logic        LSU_READY,
  output logic        STALL_REQ,
  output logic [31:0] PEND,
  output logic [4:0]  RD,
  output logic [31:0] DIN,
  output logic        WR
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;
  logic [SW-1:0] starve;

  logic [DEPTH-1:0]             slot_vld;
  logic [DEPTH-1:0][4:0]        slot_rd;
  logic [DEPTH-1:0][31:0]       slot_data;
  logic [DEPTH-1:0][31:0]       slot_pend;
  logic [DEPTH-1:0]             slot_push, slot_pop;

  logic nonempty, alu_ok, push_en, pop_en, sel_alu;

  assign nonempty  = (count != '0);
  assign LSU_READY = (count < FULL);
  assign STALL_REQ = (starve == SMAX) && nonempty;
  assign alu_ok    = ALU_VALID && (ALU_RD != 5'd0);
  // rd==0 loads complete the handshake but are dropped here
  assign push_en   = LSU_VALID && LSU_READY && (LSU_RD != 5'd0);
  assign pop_en    = STALL_REQ || (!alu_ok && nonempty);
  assign sel_alu   = !STALL_REQ && alu_ok;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    localparam logic [AW-1:0] IDX = AW'(i);
    assign slot_push[i] = push_en && (wptr == IDX);
    assign slot_pop[i]  = pop_en  && (rptr == IDX);
    reg_writeback_slot u_slot (
      .CLK     (CLK),
      .RSTN    (RSTN),
      .push    (slot_push[i]),
      .pop     (slot_pop[i]),
      .rd_in   (LSU_RD),
      .data_in (LSU_DATA),
      .vld     (slot_vld[i]),
      .rd      (slot_rd[i]),
      .data    (slot_data[i]),
      .pend    (slot_pend[i])
    );
  end

  always_comb begin
    PEND = '0;
    for (int i = 0; i < DEPTH; i++) PEND = PEND | slot_pend[i];
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push_en) wptr <= wptr + 1'b1;
      if (pop_en)  rptr <= rptr + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Counts consecutive ALU wins over a waiting load; saturates at SMAX
  always_ff @(posedge CLK) begin
    if (!RSTN)                          starve <= '0;
    else if (pop_en || !nonempty)       starve <= '0;
    else if (sel_alu && starve != SMAX) starve <= starve + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      WR  <= 1'b0;
      RD  <= '0;
      DIN <= '0;
    end else if (pop_en) begin
      WR  <= 1'b1;
      RD  <= slot_rd[rptr];
      DIN <= slot_data[rptr];
    end else if (sel_alu) begin
      WR  <= 1'b1;
      RD  <= ALU_RD;
      DIN <= ALU_DATA;
    end else begin
      WR  <= 1'b0;
    end
  end

  logic unused_vld;
  assign unused_vld = ^slot_vld;
endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: hand-computed write sequences and flag values.

module tb_reg_writeback;
  logic        CLK = 1'b0;
  logic        RSTN;
  logic        ALU_VALID, LSU_VALID;
  logic [4:0]  ALU_RD, LSU_RD;
  logic [31:0] ALU_DATA, LSU_DATA;
  logic        LSU_READY, STALL_REQ, WR;
  logic [31:0] PEND, DIN;
  logic [4:0]  RD;

  int n_chk  = 0;
  int n_fail = 0;
  logic [36:0] wlog[$];

  reg_writeback #(.DEPTH(4), .STARVE_MAX(3)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .ALU_VALID(ALU_VALID), .ALU_RD(ALU_RD), .ALU_DATA(ALU_DATA),
    .LSU_VALID(LSU_VALID), .LSU_RD(LSU_RD), .LSU_DATA(LSU_DATA),
    .LSU_READY(LSU_READY), .STALL_REQ(STALL_REQ), .PEND(PEND),
    .RD(RD), .DIN(DIN), .WR(WR)
  );

  always #5 CLK = ~CLK;

  // every write seen on the port, in order
  always @(negedge CLK) if (WR) wlog.push_back({RD, DIN});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    ALU_VALID = 0; ALU_RD = 0; ALU_DATA = 0;
    LSU_VALID = 0; LSU_RD = 0; LSU_DATA = 0;
  endtask

  logic [36:0] exp3[10];

  initial begin
    idle();
    RSTN = 0;
    tick(); tick();
    RSTN = 1;
    chk("rst_wr", WR, 0);
    chk("rst_rd", RD, 0);
    chk("rst_din", DIN, 0);
    chk("rst_pend", PEND, 0);
    chk("rst_ready", LSU_READY, 1);
    chk("rst_stall", STALL_REQ, 0);

    // 1) single ALU write
    ALU_VALID = 1; ALU_RD = 5; ALU_DATA = 32'hDEADBEEF;
    tick(); idle();
    chk("t1_wr", WR, 1);
    chk("t1_rd", RD, 5);
    chk("t1_din", DIN, 32'hDEADBEEF);
    tick();
    chk("t1_wr_off", WR, 0);
    chk("t1_rd_hold", RD, 5);

    // 2) single load
    LSU_VALID = 1; LSU_RD = 7; LSU_DATA = 32'h12345678;
    chk("t2_ready", LSU_READY, 1);
    tick(); idle();
    chk("t2_pend", PEND, 32'h0000_0080);
    chk("t2_wr_early", WR, 0);
    tick();
    chk("t2_wr", WR, 1);
    chk("t2_rd", RD, 7);
    chk("t2_din", DIN, 32'h12345678);
    chk("t2_pend_clr", PEND, 0);
    tick();
    chk("t2_wr_off", WR, 0);

    // 3) fill FIFO while ALU is busy, fifth load waits
    wlog.delete();
    for (int i = 0; i < 4; i++) begin
      ALU_VALID = 1; ALU_RD = 5'(1 + i); ALU_DATA = 32'hA0 + i;
      LSU_VALID = 1; LSU_RD = 5'(10 + i); LSU_DATA = 32'h100 + i;
      tick();
    end
    chk("t3_full_ready", LSU_READY, 0);
    chk("t3_full_stall", STALL_REQ, 1);
    chk("t3_full_pend", PEND, 32'h0000_3C00);
    ALU_VALID = 1; ALU_RD = 5;  ALU_DATA = 32'hA4;
    LSU_VALID = 1; LSU_RD = 14; LSU_DATA = 32'h104;
    tick();
    chk("t3_pop_wr", WR, 1);
    chk("t3_pop_rd", RD, 10);
    chk("t3_ready_back", LSU_READY, 1);
    chk("t3_stall_off", STALL_REQ, 0);
    tick(); idle();
    chk("t3_alu_after_stall", RD, 5);
    for (int i = 0; i < 6; i++) tick();
    exp3 = '{{5'd1, 32'hA0}, {5'd2, 32'hA1}, {5'd3, 32'hA2}, {5'd4, 32'hA3},
             {5'd10, 32'h100}, {5'd5, 32'hA4}, {5'd11, 32'h101},
             {5'd12, 32'h102}, {5'd13, 32'h103}, {5'd14, 32'h104}};
    chk("t3_nwrites", wlog.size(), 10);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t3_write%0d", i), (i < wlog.size()) ? wlog[i] : 37'h0, exp3[i]);
    chk("t3_pend_end", PEND, 0);

    // 4) starvation guard
    LSU_VALID = 1; LSU_RD = 20; LSU_DATA = 32'h200;
    tick(); idle();
    chk("t4_pend", PEND, 32'h0010_0000);
    for (int i = 1; i <= 3; i++) begin
      ALU_VALID = 1; ALU_RD = 21; ALU_DATA = 32'h300 + i;
      tick();
      chk($sformatf("t4_alu%0d_rd", i), RD, 21);
      chk($sformatf("t4_alu%0d_din", i), DIN, 32'h300 + i);
      chk($sformatf("t4_stall%0d", i), STALL_REQ, (i == 3));
    end
    ALU_DATA = 32'h304;
    tick();
    chk("t4_pop_rd", RD, 20);
    chk("t4_pop_din", DIN, 32'h200);
    chk("t4_stall_off", STALL_REQ, 0);
    tick(); idle();
    chk("t4_held_alu", DIN, 32'h304);
    tick();

    // 5) r0 destinations are dropped
    wlog.delete();
    ALU_VALID = 1; ALU_RD = 0; ALU_DATA = 32'hFFFF_FFFF;
    LSU_VALID = 1; LSU_RD = 0; LSU_DATA = 32'h5555_5555;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_ready%0d", i), LSU_READY, 1);
      tick();
      chk($sformatf("t5_wr%0d", i), WR, 0);
      chk($sformatf("t5_pend%0d", i), PEND, 0);
    end
    idle();
    tick();
    chk("t5_nwrites", wlog.size(), 0);

    // 6) reset with entries queued
    for (int i = 0; i < 3; i++) begin
      ALU_VALID = 1; ALU_RD = 5'(1 + i); ALU_DATA = 32'h40 + i;
      LSU_VALID = 1; LSU_RD = 5'(25 + i); LSU_DATA = 32'h500 + i;
      tick();
    end
    idle();
    chk("t6_pend_q", PEND, 32'h0E00_0000);
    RSTN = 0;
    tick();
    chk("t6_wr", WR, 0);
    chk("t6_pend", PEND, 0);
    chk("t6_ready", LSU_READY, 1);
    chk("t6_din", DIN, 0);
    RSTN = 1;
    wlog.delete();
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_stale", wlog.size(), 0);
    chk("t6_wr_end", WR, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
